sound_sequencer: RTL

Front-end controller for sound_controller. Collects one-cycle sound request pulses from the game logic (ping, pong, go, stop) and holds one pending flag per sound. Grants requests by fixed priority and plays each sound for a programmed number of 1 ms ticks, followed by a silent gap. Drives the `code_sound`/`mute` inputs of sound_controller.

---
 rtl/sound_pkg.sv | 49 ++++
 rtl/tick_prescaler.sv | 22 ++
 rtl/sound_sequencer.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/sound_pkg.sv
// Shared constants, priority helpers and state encoding for the sound sequencer.
package sound_pkg;

   localparam logic [2:0] CODE_PING = 3'b010;
   localparam logic [2:0] CODE_PONG = 3'b001;
   localparam logic [2:0] CODE_GO   = 3'b011;
   localparam logic [2:0] CODE_STOP = 3'b000;

   localparam int IDX_PING = 0;
   localparam int IDX_PONG = 1;
   localparam int IDX_GO   = 2;
   localparam int IDX_STOP = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PLAY = 2'd1,
      GAP  = 2'd2
   } state_t;

   // One-hot winner, order go > stop > ping > pong.
   function automatic logic [3:0] prio_pick(input logic [3:0] p);
      logic [3:0] w;
      w = '0;
      if (p[IDX_GO])        w[IDX_GO]   = 1'b1;
      else if (p[IDX_STOP]) w[IDX_STOP] = 1'b1;
      else if (p[IDX_PING]) w[IDX_PING] = 1'b1;
      else if (p[IDX_PONG]) w[IDX_PONG] = 1'b1;
      return w;
   endfunction

   function automatic logic [1:0] prio_rank(input logic [3:0] sel);
      logic [1:0] r;
      r = 2'd0;
      if (sel[IDX_GO])        r = 2'd3;
      else if (sel[IDX_STOP]) r = 2'd2;
      else if (sel[IDX_PING]) r = 2'd1;
      return r;
   endfunction

   function automatic logic [2:0] code_of(input logic [3:0] sel);
      logic [2:0] c;
      c = CODE_STOP;
      if (sel[IDX_GO])        c = CODE_GO;
      else if (sel[IDX_PING]) c = CODE_PING;
      else if (sel[IDX_PONG]) c = CODE_PONG;
      return c;
   endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider producing a one-cycle tick every CLK_DIV clocks; restart zeroes it.
module tick_prescaler #(
   parameter int CLK_DIV = 12000
) (
   input  logic clk,
   input  logic rst,
   input  logic restart,
   output logic tick
);

   localparam int CW = $clog2(CLK_DIV);

   logic [CW-1:0] cnt;

   assign tick = (cnt == CW'(CLK_DIV - 1));

   always_ff @(posedge clk) begin
      if (rst || restart || tick) cnt <= '0;
      else                        cnt <= cnt + 1'b1;
   end

endmodule

// File: rtl/sound_sequencer.sv
// Request collector, fixed-priority arbiter and tone/gap timer in front of sound_controller.
// Optional build macro SOUND_PREEMPT_EN lets a higher-priority request abort the playing tone.
//
// state | meaning
// IDLE  | silent, waiting for an enabled pending request
// PLAY  | tone running for LEN ticks, mute=0
// GAP   | silent gap of GAP_TICKS ticks, code held
module sound_sequencer
   import sound_pkg::*;
#(
   parameter int CLK_DIV    = 12000,
   parameter int PING_TICKS = 50,
   parameter int PONG_TICKS = 50,
   parameter int GO_TICKS   = 200,
   parameter int STOP_TICKS = 400,
   parameter int GAP_TICKS  = 20
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sound_en,
   input  logic [3:0] req,
   output logic [3:0] ack,
   output logic [2:0] code_sound,
   output logic       mute,
   output logic       busy
);

   localparam logic [15:0] GAP_LAST = (GAP_TICKS > 0) ? 16'(GAP_TICKS - 1) : 16'd0;

   state_t      state, state_nx;
   logic [3:0]  pending, pending_nx;
   logic [3:0]  cur_sel, cur_sel_nx;
   logic [3:0]  ack_nx;
   logic [2:0]  code_nx;
   logic [3:0]  winner;
   logic [3:0]  grant;
   logic [15:0] tick_cnt;
   logic [15:0] play_last;
   logic        tick;
   logic        restart;
   logic        play_done;
   logic        gap_done;
   logic        preempt;

   tick_prescaler #(.CLK_DIV(CLK_DIV)) u_prescaler (
      .clk     (clk),
      .rst     (rst),
      .restart (restart),
      .tick    (tick)
   );

   assign winner = prio_pick(pending);

   always_comb begin
      play_last = 16'(PONG_TICKS - 1);
      if (cur_sel[IDX_GO])        play_last = 16'(GO_TICKS - 1);
      else if (cur_sel[IDX_STOP]) play_last = 16'(STOP_TICKS - 1);
      else if (cur_sel[IDX_PING]) play_last = 16'(PING_TICKS - 1);
   end

   assign play_done = tick && (tick_cnt == play_last);
   assign gap_done  = tick && (tick_cnt == GAP_LAST);

`ifdef SOUND_PREEMPT_EN
   assign preempt = (state == PLAY) && (|pending) && (prio_rank(winner) > prio_rank(cur_sel));
`else
   assign preempt = 1'b0;
`endif

   always_comb begin
      state_nx   = state;
      grant      = '0;
      restart    = 1'b0;
      ack_nx     = '0;
      code_nx    = code_sound;
      cur_sel_nx = cur_sel;
      if (!sound_en) begin
         state_nx = IDLE;
         restart  = (state != IDLE);
      end else begin
         case (state)
            IDLE: begin
               if (|pending) begin
                  grant    = winner;
                  state_nx = PLAY;
                  restart  = 1'b1;
               end
            end
            PLAY: begin
               if (preempt) begin
                  grant   = winner;
                  restart = 1'b1;
               end else if (play_done) begin
                  state_nx = (GAP_TICKS == 0) ? IDLE : GAP;
                  restart  = 1'b1;
               end
            end
            GAP: begin
               if (gap_done) begin
                  state_nx = IDLE;
                  restart  = 1'b1;
               end
            end
            default: begin
               state_nx = IDLE;
               restart  = 1'b1;
            end
         endcase
      end
      if (|grant) begin
         ack_nx     = grant;
         code_nx    = code_of(grant);
         cur_sel_nx = grant;
      end
      // A request landing in its own grant cycle is absorbed by the clear.
      pending_nx = sound_en ? ((pending | req) & ~grant) : 4'b0000;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         pending    <= '0;
         ack        <= '0;
         code_sound <= CODE_STOP;
         cur_sel    <= '0;
      end else begin
         state      <= state_nx;
         pending    <= pending_nx;
         ack        <= ack_nx;
         code_sound <= code_nx;
         cur_sel    <= cur_sel_nx;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || restart)                  tick_cnt <= '0;
      else if (tick && tick_cnt != 16'hFFFF) tick_cnt <= tick_cnt + 16'd1;
   end

   assign mute = (state != PLAY);
   assign busy = (state != IDLE);

endmodule
